// File: rtl/mem_stream_reader_if.sv
// Bundle of generator, block-RAM and output-stream signals around the stream reader.
interface mem_stream_reader_if #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_status;
  logic              gen_ack;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              done;
  logic              busy;

  // Surrounding system: control, address generator, RAM data and stream sink.
  modport master (
    output start, gen_addr, gen_status, mem_rdata, out_ready,
    input  gen_ack, mem_en, mem_addr, out_data, out_valid, out_last, done, busy
  );

  // The stream reader itself.
  modport slave (
    input  start, gen_addr, gen_status, mem_rdata, out_ready,
    output gen_ack, mem_en, mem_addr, out_data, out_valid, out_last, done, busy
  );
endinterface

// File: rtl/mem_stream_reader.sv
// Acknowledges generator addresses, reads a block RAM and streams the words out
// through a small credit-protected FIFO, flagging the word from LAST_ADDR.
module mem_stream_reader #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LAST_ADDR  = 8191,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  mem_stream_reader_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned CRD_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              issue;
  logic              at_last;
  logic              credit_ok;
  logic              inflight;
  logic              issue_last;
  logic              push;
  logic              pop;
  logic              nonempty;
  logic              head_last;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  // Credit counts stored words plus the read in flight; a same-cycle pop gives none.
  assign at_last   = (bus.gen_addr == ADDR_W'(LAST_ADDR));
  assign credit_ok = (CRD_W'(count) + CRD_W'(inflight)) < CRD_W'(FIFO_DEPTH);
  assign nonempty  = (count != '0);
  assign head_last = nonempty & fifo_last[rd_ptr];
  assign push      = inflight;
  assign pop       = nonempty & bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and read issue; the last-address term keeps the final word
  // readable even if the generator drops status before it is acked.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        issue = credit_ok & (bus.gen_status | at_last);
        if (issue & at_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop & head_last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Track the read whose data returns next cycle, and whether it is the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      issue_last <= 1'b0;
    end else begin
      inflight   <= issue;
      issue_last <= issue & at_last;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.mem_rdata;
      fifo_last[wr_ptr] <= issue_last;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.gen_ack   = issue;
  assign bus.mem_en    = issue;
  assign bus.mem_addr  = bus.gen_addr;
  assign bus.out_data  = fifo_data[rd_ptr];
  assign bus.out_valid = nonempty;
  assign bus.out_last  = head_last;
  assign bus.done      = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DRAIN);
endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: generator and RAM models drive the reader, a
// sweep-level model predicts every output each cycle, and directed scenarios
// pin the model with hand-computed numbers.
module tb_mem_stream_reader;
  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 32;
  localparam int LAST    = 8191;
  localparam int DEPTH   = 4;
  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(LAST), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Environment state (owned by the stimulus process).
  int cyc        = 0;
  int gen_cnt    = 0;
  int stall_addr = -1;
  int stall_left = 0;
  bit hold_last  = 1'b0;
  bit force_now  = 1'b0;

  // Observations handed from the compare process to the RAM/generator models.
  bit                ack_seen     = 1'b0;
  bit                gen_ack_seen = 1'b0;
  logic [ADDR_W-1:0] ack_addr     = '0;

  // Sweep model: phase, acks issued through t-1 and t-2, beats accepted.
  int m_phase = P_IDLE;
  int m_a1    = 0;
  int m_a2    = 0;
  int m_pops  = 0;

  // Per-sweep statistics observed on the DUT.
  int          n_beats, n_acks, n_last, n_ack_last;
  int          first_valid_cyc, last_hs_cyc, done_cyc;
  int          force_acks, force_cycles;
  logic [31:0] last_beat_data;

  bit          p_stall = 1'b0;
  bit          p_rst   = 1'b1;
  logic [31:0] p_data  = '0;
  logic        p_last  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_stats();
    n_beats = 0; n_acks = 0; n_last = 0; n_ack_last = 0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    force_acks = 0; force_cycles = 0; last_beat_data = '0;
  endtask

  // Sequential address generator: status drops when exhausted or when forced.
  task automatic drive_gen();
    force_now = 1'b0;
    if (gen_cnt == stall_addr && stall_left > 0) begin
      force_now  = 1'b1;
      stall_left = stall_left - 1;
    end
    bus.gen_addr   = ADDR_W'(gen_cnt);
    bus.gen_status = (gen_cnt <= LAST) && !force_now && !(hold_last && gen_cnt == LAST);
  endtask

  // Advance one clock: generator steps on ack, RAM returns mem[a] = 3a.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) gen_cnt = 0;
    else if (gen_ack_seen) gen_cnt = gen_cnt + 1;
    bus.mem_rdata = ack_seen ? (32'(ack_addr) * 32'd3) : DATA_W'($urandom);
    bus.start     = 1'b0;
    drive_gen();
  endtask

  // Compare DUT against the sweep model every cycle, then advance the model.
  always @(negedge clk) begin : cmp
    bit          e_ack, e_valid, e_last, e_done, e_busy, hs;
    logic [31:0] e_data;

    e_ack   = (m_phase == P_RUN) && (m_a1 - m_pops < DEPTH) &&
              (bus.gen_status || bus.gen_addr == ADDR_W'(LAST));
    e_valid = (m_a2 > m_pops);
    e_data  = 32'(m_pops * 3);
    e_last  = (m_pops == LAST);
    e_done  = (m_phase == P_DONE);
    e_busy  = (m_phase == P_RUN) || (m_phase == P_DRAIN);

    check("gen_ack", 64'(bus.gen_ack), 64'(e_ack));
    check("mem_en", 64'(bus.mem_en), 64'(e_ack));
    check("mem_addr", 64'(bus.mem_addr), 64'(bus.gen_addr));
    check("out_valid", 64'(bus.out_valid), 64'(e_valid));
    if (e_valid) begin
      check("out_data", 64'(bus.out_data), 64'(e_data));
      check("out_last", 64'(bus.out_last), 64'(e_last));
    end
    check("done", 64'(bus.done), 64'(e_done));
    check("busy", 64'(bus.busy), 64'(e_busy));
    if (p_stall && !p_rst) begin
      check("stalled valid held", 64'(bus.out_valid), 64'(1));
      check("stalled data held", 64'(bus.out_data), 64'(p_data));
      check("stalled last held", 64'(bus.out_last), 64'(p_last));
    end

    if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.out_valid && bus.out_ready) begin
      n_beats++;
      last_hs_cyc = cyc;
      if (bus.out_last) begin
        n_last++;
        last_beat_data = bus.out_data;
      end
    end
    if (bus.gen_ack) begin
      n_acks++;
      if (bus.mem_addr == ADDR_W'(LAST)) n_ack_last++;
    end
    if (bus.done && done_cyc < 0) done_cyc = cyc;
    if (force_now) begin
      force_cycles++;
      if (bus.gen_ack) force_acks++;
    end

    ack_seen     = bus.mem_en;
    gen_ack_seen = bus.gen_ack;
    ack_addr     = bus.mem_addr;
    p_stall      = bus.out_valid && !bus.out_ready;
    p_data       = bus.out_data;
    p_last       = bus.out_last;
    p_rst        = rst;

    hs = e_valid && bus.out_ready;
    if (rst) begin
      m_phase = P_IDLE; m_a1 = 0; m_a2 = 0; m_pops = 0;
    end else begin
      m_a2   = m_a1;
      m_a1   = m_a1 + (e_ack ? 1 : 0);
      m_pops = m_pops + (hs ? 1 : 0);
      case (m_phase)
        P_IDLE, P_DONE: if (bus.start) begin
          m_phase = P_RUN; m_a1 = 0; m_a2 = 0; m_pops = 0;
          reset_stats();
        end
        P_RUN:   if (e_ack && bus.gen_addr == ADDR_W'(LAST)) m_phase = P_DRAIN;
        P_DRAIN: if (hs && e_last) m_phase = P_DONE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  initial begin
    int  snap;
    bit  mid_done, end_done, drain_done;

    reset_stats();
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    bus.mem_rdata = '0;
    drive_gen();

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset gen_ack", 64'(bus.gen_ack), 64'(0));
    check("reset mem_en", 64'(bus.mem_en), 64'(0));
    check("reset out_valid", 64'(bus.out_valid), 64'(0));
    check("reset out_last", 64'(bus.out_last), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset busy", 64'(bus.busy), 64'(0));

    // Sweep A: plain full sweep, out_ready held high.
    tick();
    cyc = 0;
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 9000 && m_phase != P_DONE; i++) tick();
    repeat (2) tick();
    check("A completes", 64'(m_phase == P_DONE), 64'(1));
    check("A first valid cycle", 64'(first_valid_cyc), 64'(3));
    check("A beats", 64'(n_beats), 64'(8192));
    check("A acks", 64'(n_acks), 64'(8192));
    check("A last count", 64'(n_last), 64'(1));
    check("A last data", 64'(last_beat_data), 64'(24573));
    check("A last handshake cycle", 64'(last_hs_cyc), 64'(8194));
    check("A done cycle", 64'(done_cyc), 64'(8195));

    // Sweep B from DONE: start in RUN/DRAIN, status gap at 100, output stall,
    // status low at the final address with the FIFO backed up.
    gen_cnt = 0;
    stall_addr = 100;
    stall_left = 5;
    hold_last = 1'b1;
    drive_gen();
    cyc = 0;
    bus.start = 1'b1;
    tick();
    mid_done = 1'b0; end_done = 1'b0; drain_done = 1'b0;
    for (int i = 0; i < 12000 && m_phase != P_DONE; i++) begin
      if (cyc == 50) bus.start = 1'b1;
      if (!mid_done && n_beats >= 3000) begin
        bus.out_ready = 1'b0;
        snap = n_acks;
        repeat (20) tick();
        check("B acks during output stall <= 4", 64'((n_acks - snap) <= DEPTH), 64'(1));
        bus.out_ready = 1'b1;
        mid_done = 1'b1;
      end
      if (!end_done && gen_cnt >= 8189) begin
        bus.out_ready = 1'b0;
        repeat (15) tick();
        bus.out_ready = 1'b1;
        end_done = 1'b1;
      end
      if (!drain_done && m_phase == P_DRAIN) begin
        bus.start = 1'b1;
        drain_done = 1'b1;
      end
      tick();
    end
    repeat (3) tick();
    check("B completes", 64'(m_phase == P_DONE), 64'(1));
    check("B beats", 64'(n_beats), 64'(8192));
    check("B acks", 64'(n_acks), 64'(8192));
    check("B final address acked once", 64'(n_ack_last), 64'(1));
    check("B last count", 64'(n_last), 64'(1));
    check("B last data", 64'(last_beat_data), 64'(24573));
    check("B status-low cycles", 64'(force_cycles), 64'(5));
    check("B acks while status low", 64'(force_acks), 64'(0));
    hold_last = 1'b0;
    stall_addr = -1;

    // Sweep C: reset at beat 500 while words are buffered.
    repeat (2) tick();
    gen_cnt = 0;
    drive_gen();
    cyc = 0;
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 1000 && n_beats < 500; i++) tick();
    check("C reached beat 500", 64'(n_beats >= 500), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("C fifo non-empty at reset", 64'(bus.out_valid), 64'(1));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("C post-reset out_valid", 64'(bus.out_valid), 64'(0));
    check("C post-reset gen_ack", 64'(bus.gen_ack), 64'(0));
    check("C post-reset busy", 64'(bus.busy), 64'(0));
    check("C post-reset done", 64'(bus.done), 64'(0));
    check("C post-reset out_last", 64'(bus.out_last), 64'(0));

    // Sweep D: clean sweep after reset with a bursty sink.
    repeat (2) tick();
    cyc = 0;
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 15000 && m_phase != P_DONE; i++) begin
      bus.out_ready = (cyc % 3 != 2);
      tick();
    end
    bus.out_ready = 1'b1;
    repeat (2) tick();
    check("D completes", 64'(m_phase == P_DONE), 64'(1));
    check("D beats", 64'(n_beats), 64'(8192));
    check("D acks", 64'(n_acks), 64'(8192));
    check("D last count", 64'(n_last), 64'(1));
    check("D last data", 64'(last_beat_data), 64'(24573));
    check("D first valid cycle", 64'(first_valid_cyc), 64'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
